// File: rtl/d_frame_assembler_pkg.sv
// Shared types for the d-beat frame assembler: beat type, FSM state codes, frame struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package d_frame_assembler_pkg;

   localparam int C_ANOTHER_SIZE = 10;   // beats per full frame
   localparam int D_SIZE         = 3;    // bits per beat

   typedef logic [D_SIZE-1:0] dT;

   typedef struct packed {
      dT d;
   } dSt;

   typedef enum logic [3:0] {
      CS_IDLE    = 4'h0,
      CS_COLLECT = 4'h1,
      CS_EMIT    = 4'h2
   } cStateT;

   localparam cStateT ST_IDLE    = CS_IDLE;
   localparam cStateT ST_COLLECT = CS_COLLECT;
   localparam cStateT ST_EMIT    = CS_EMIT;

   // Beat i of frm_data sits at bits [i*D_SIZE +: D_SIZE], matching the flat frame bus.
   typedef struct packed {
      dT                        frm_parity;
      logic [3:0]               frm_count;
      dT [C_ANOTHER_SIZE-1:0]   frm_data;
   } frmSt;

   // Running parity is a plain bitwise XOR; no carry between bits.
   function automatic dT par_step(dT acc, dT beat);
      return acc ^ beat;
   endfunction

endpackage

// File: rtl/d_frame_assembler_if.sv
// Beat-in / frame-out bus bundle for the frame assembler.
// Latency: n/a (wires only).
// Backpressure: d_ready throttles beats, frm_ready holds a pending frame.
// Ports: master = environment side (drives beats, flush, frm_ready);
//        slave  = assembler side (drives d_ready and the frame outputs).
interface d_frame_assembler_if
   import d_frame_assembler_pkg::*;
#(
   parameter int FRAME_LEN = C_ANOTHER_SIZE,
   parameter int D_W       = D_SIZE,
   parameter int CNT_W     = 4
) ();

   logic                    d_valid;
   logic [D_W-1:0]          d_data;
   logic                    d_ready;
   logic                    flush;
   logic                    frm_valid;
   logic [FRAME_LEN*D_W-1:0] frm_data;
   logic [CNT_W-1:0]        frm_count;
   logic [D_W-1:0]          frm_parity;
   logic                    frm_ready;

   modport master (
      output d_valid, d_data, flush, frm_ready,
      input  d_ready, frm_valid, frm_data, frm_count, frm_parity
   );

   modport slave (
      input  d_valid, d_data, flush, frm_ready,
      output d_ready, frm_valid, frm_data, frm_count, frm_parity
   );

endinterface

// File: rtl/d_frame_slot_reg.sv
// Slot array for one frame: writes a beat into the slot chosen by idx_i, clears all slots.
// Latency: write visible on slots_o one cycle after load_i.
// Backpressure: none; caller gates load_i/clear_i.
// Ports: load_i/idx_i/dat_i write one slot, clear_i zeroes every slot (wins over load_i),
//        slots_o is the flat frame with slot i at [i*D_W +: D_W].
module d_frame_slot_reg #(
   parameter int N     = 10,
   parameter int D_W   = 3,
   parameter int IDX_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               clear_i,
   input  logic [IDX_W-1:0]   idx_i,
   input  logic [D_W-1:0]     dat_i,
   output logic [N*D_W-1:0]   slots_o
);

   logic [N*D_W-1:0] slots_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots_q <= '0;
      end else if (clear_i) begin
         slots_q <= '0;
      end else if (load_i) begin
         for (int i = 0; i < N; i++) begin
            if (idx_i == IDX_W'(i)) begin
               slots_q[i*D_W +: D_W] <= dat_i;
            end
         end
      end
   end

   assign slots_o = slots_q;

endmodule

// File: rtl/d_frame_assembler.sv
// Packs a run of D_W-bit beats into one frame with beat count and XOR parity; flush closes early.
// Latency: frame valid one cycle after the last beat (or flush) is accepted.
// Backpressure: d_ready drops while a frame is pending; frame held until frm_ready.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries beat input,
//        flush and the frame handshake; state exposes the FSM code for debug.
module d_frame_assembler
   import d_frame_assembler_pkg::*;
#(
   parameter int FRAME_LEN = C_ANOTHER_SIZE,
   parameter int D_W       = D_SIZE,
   parameter int CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   d_frame_assembler_if.slave   bus,
   output cStateT               state
);

   generate
      if (FRAME_LEN < 1 || FRAME_LEN > 15 || FRAME_LEN >= (1 << CNT_W)) begin : g_bad_len
         $error("d_frame_assembler: FRAME_LEN out of range for CNT_W");
      end
   endgenerate

   localparam logic [CNT_W-1:0] FL_CNT = CNT_W'(FRAME_LEN);

   cStateT            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [D_W-1:0]    par_q;
   logic              frm_vld_q;
   logic              d_rdy_q;

   logic              accept;
   logic              clear;
   logic [CNT_W-1:0]  cnt_inc;
   logic [D_W-1:0]    beat_dat;
   logic [D_W-1:0]    par_nxt;
   logic [FRAME_LEN*D_W-1:0] slots;

   assign beat_dat = bus.d_data;
   // d_ready is a register, so acceptance never depends on frm_ready in the same cycle.
   assign accept   = bus.d_valid && d_rdy_q;
   assign cnt_inc  = cnt_q + 1'b1;
   assign par_nxt  = par_q ^ beat_dat;
   // Slots clear on the frame handshake, and on any illegal state code as a recovery.
   assign clear    = ((state_q == ST_EMIT) && bus.frm_ready) ||
                     ((state_q != ST_IDLE) && (state_q != ST_COLLECT) && (state_q != ST_EMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         par_q     <= '0;
         frm_vld_q <= 1'b0;
         d_rdy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               d_rdy_q <= 1'b1;
               // A lone flush has nothing to close, so it is dropped here.
               if (accept) begin
                  cnt_q <= cnt_inc;
                  par_q <= par_nxt;
                  if ((FRAME_LEN == 1) || bus.flush) begin
                     state_q   <= ST_EMIT;
                     frm_vld_q <= 1'b1;
                     d_rdy_q   <= 1'b0;
                  end else begin
                     state_q <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               d_rdy_q <= 1'b1;
               if (accept) begin
                  cnt_q <= cnt_inc;
                  par_q <= par_nxt;
               end
               // A beat arriving alongside flush is part of the closed frame.
               if ((accept && (cnt_inc == FL_CNT)) || bus.flush) begin
                  state_q   <= ST_EMIT;
                  frm_vld_q <= 1'b1;
                  d_rdy_q   <= 1'b0;
               end
            end
            ST_EMIT: begin
               if (bus.frm_ready) begin
                  state_q   <= ST_IDLE;
                  cnt_q     <= '0;
                  par_q     <= '0;
                  frm_vld_q <= 1'b0;
                  d_rdy_q   <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               cnt_q     <= '0;
               par_q     <= '0;
               frm_vld_q <= 1'b0;
               d_rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   d_frame_slot_reg #(
      .N     (FRAME_LEN),
      .D_W   (D_W),
      .IDX_W (CNT_W)
   ) u_slots (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (accept),
      .clear_i (clear),
      .idx_i   (cnt_q),
      .dat_i   (beat_dat),
      .slots_o (slots)
   );

   assign bus.d_ready    = d_rdy_q;
   assign bus.frm_valid  = frm_vld_q;
   assign bus.frm_data   = slots;
   assign bus.frm_count  = cnt_q;
   assign bus.frm_parity = par_q;
   assign state          = state_q;

endmodule

// File: tb/tb_d_frame_assembler.sv
// Directed bench for d_frame_assembler: full frame, backpressure, flush cases, reset mid-frame.
// Latency: checks frame valid one cycle after the closing beat.
// Backpressure: holds frm_ready low to verify the frame is held stable.
module tb_d_frame_assembler;
   import d_frame_assembler_pkg::*;

   localparam int FRAME_LEN = 10;
   localparam int D_W       = 3;
   localparam int CNT_W     = 4;

   logic   clk;
   logic   rst_n;
   cStateT state;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference frame built from the beats the bench sends.
   logic [31:0] exp_data;
   logic [31:0] exp_par;
   int          exp_cnt;

   d_frame_assembler_if #(.FRAME_LEN(FRAME_LEN), .D_W(D_W), .CNT_W(CNT_W)) bus ();

   d_frame_assembler #(.FRAME_LEN(FRAME_LEN), .D_W(D_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .state (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      exp_data = '0;
      exp_par  = '0;
      exp_cnt  = 0;
   endtask

   task automatic send_beat(input logic [2:0] d, input logic fl);
      int t;
      t = 0;
      while (!bus.d_ready && t < 20) begin
         step();
         t++;
      end
      if (t >= 20) chk("d_ready_timeout", 32'(bus.d_ready), 32'd1);
      bus.d_valid = 1'b1;
      bus.d_data  = d;
      bus.flush   = fl;
      step();
      bus.d_valid = 1'b0;
      bus.flush   = 1'b0;
      exp_data = exp_data | (32'(d) << (3 * exp_cnt));
      exp_par  = exp_par ^ 32'(d);
      exp_cnt++;
   endtask

   task automatic check_frame(input string tag, input logic [31:0] cnt,
                              input logic [31:0] dat, input logic [31:0] par);
      chk({tag, "_valid"},  32'(bus.frm_valid),  32'd1);
      chk({tag, "_count"},  32'(bus.frm_count),  cnt);
      chk({tag, "_data"},   32'(bus.frm_data),   dat);
      chk({tag, "_parity"}, 32'(bus.frm_parity), par);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_state"},  32'(state),         32'h0);
      chk({tag, "_frmvld"}, 32'(bus.frm_valid), 32'd0);
      chk({tag, "_drdy"},   32'(bus.d_ready),   32'd1);
   endtask

   logic [2:0] full_a [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
   logic [2:0] full_b [10] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
   logic [2:0] full_c [10] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};

   initial begin
      rst_n         = 1'b0;
      bus.d_valid   = 1'b0;
      bus.d_data    = '0;
      bus.flush     = 1'b0;
      bus.frm_ready = 1'b0;
      model_clear();

      // Reset values
      step();
      step();
      chk("rst_state",  32'(state),          32'h0);
      chk("rst_drdy",   32'(bus.d_ready),    32'd0);
      chk("rst_frmvld", 32'(bus.frm_valid),  32'd0);
      chk("rst_data",   32'(bus.frm_data),   32'd0);
      chk("rst_count",  32'(bus.frm_count),  32'd0);
      chk("rst_parity", 32'(bus.frm_parity), 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_drdy", 32'(bus.d_ready), 32'd1);

      // Full frame with downstream always ready
      bus.frm_ready = 1'b1;
      model_clear();
      for (int i = 0; i < 10; i++) begin
         if (i == 9) chk("full_no_early_vld", 32'(bus.frm_valid), 32'd0);
         send_beat(full_a[i], 1'b0);
      end
      check_frame("full", 32'd10, exp_data, 32'h1);
      chk("full_drdy_low", 32'(bus.d_ready), 32'd0);
      chk("full_state_emit", 32'(state), 32'h2);
      step();
      check_idle("full_after");

      // Backpressure: frame held for 5 cycles, junk beats/flush ignored
      bus.frm_ready = 1'b0;
      model_clear();
      for (int i = 0; i < 10; i++) send_beat(full_b[i], 1'b0);
      for (int c = 0; c < 5; c++) begin
         check_frame("bp_hold", 32'd10, exp_data, exp_par);
         chk("bp_drdy_low", 32'(bus.d_ready), 32'd0);
         bus.d_valid = 1'b1;
         bus.d_data  = 3'd5;
         bus.flush   = 1'b1;
         step();
      end
      bus.d_valid   = 1'b0;
      bus.flush     = 1'b0;
      bus.frm_ready = 1'b1;
      check_frame("bp_hs", 32'd10, exp_data, exp_par);
      step();
      check_idle("bp_after");
      chk("bp_cleared_data",  32'(bus.frm_data),   32'd0);
      chk("bp_cleared_count", 32'(bus.frm_count),  32'd0);
      bus.frm_ready = 1'b0;

      // Partial flush: 5,5,2 then flush alone
      model_clear();
      send_beat(3'd5, 1'b0);
      send_beat(3'd5, 1'b0);
      send_beat(3'd2, 1'b0);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check_frame("pflush", 32'd3, 32'h0000_00AD, 32'h2);
      bus.frm_ready = 1'b1;
      step();
      bus.frm_ready = 1'b0;
      check_idle("pflush_after");

      // Flush in the same cycle as the fourth beat
      model_clear();
      send_beat(3'd1, 1'b0);
      send_beat(3'd2, 1'b0);
      send_beat(3'd3, 1'b0);
      send_beat(3'd4, 1'b1);
      check_frame("bflush", 32'd4, 32'h0000_08D1, 32'h4);
      bus.frm_ready = 1'b1;
      step();
      bus.frm_ready = 1'b0;

      // Flush while idle does nothing
      bus.flush = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("iflush_frmvld", 32'(bus.frm_valid), 32'd0);
         chk("iflush_state",  32'(state),         32'h0);
      end
      bus.flush = 1'b0;
      chk("iflush_count", 32'(bus.frm_count), 32'd0);

      // Reset mid-frame discards the partial frame
      model_clear();
      for (int i = 0; i < 6; i++) send_beat(3'd7, 1'b0);
      chk("mid_count_pre", 32'(bus.frm_count), 32'd6);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count",  32'(bus.frm_count),  32'd0);
      chk("mid_rst_data",   32'(bus.frm_data),   32'd0);
      chk("mid_rst_parity", 32'(bus.frm_parity), 32'd0);
      chk("mid_rst_drdy",   32'(bus.d_ready),    32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      model_clear();
      for (int i = 0; i < 10; i++) begin
         chk("mid_no_vld", 32'(bus.frm_valid), 32'd0);
         send_beat(full_c[i], 1'b0);
      end
      check_frame("mid_full", 32'd10, exp_data, 32'h3);
      bus.frm_ready = 1'b1;
      step();
      bus.frm_ready = 1'b0;
      check_idle("mid_after");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/d_frame_assembler.md
Name: d_frame_assembler

Overview:
- Stream stage directly upstream of blockC.
- Collects a run of dSt beats (dT, D_SIZE=3 bits each) into one packed frame of up to C_ANOTHER_SIZE beats and hands it on with a valid/ready handshake.
- Adds the beat count and a running XOR parity.
- An explicit flush closes a partial frame early.

Parameters:
- FRAME_LEN, default C_ANOTHER_SIZE (10): beats per full frame. Legal range 1..15.
- D_W, default D_SIZE (3): width of one dT beat.
- CNT_W, default 4: width of the beat counter and frm_count.

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous, active-low reset
- d_valid  in  1  upstream beat valid
- d_data  in  D_W  beat payload (dSt.d)
- d_ready  out  1  this block accepts a beat
- flush  in  1  close the current partial frame
- frm_valid  out  1  frame available
- frm_data  out  FRAME_LEN*D_W  packed frame; beat i occupies bits [i*D_W+D_W-1 : i*D_W]
- frm_count  out  CNT_W  number of valid beats in the frame, 1..FRAME_LEN
- frm_parity  out  D_W  XOR of all beats in the frame
- frm_ready  in  1  downstream accepts the frame
- state  out  4  current FSM state, typed cStateT, for debug

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, synchronous deassert, active-low.
- Reset values: state=IDLE(4'h0), d_ready=0 while in reset then 1, frm_valid=0, frm_data=0, frm_count=0, frm_parity=0, internal counter=0.
- Beat acceptance: a beat is accepted when d_valid && d_ready. d_ready = (state != EMIT). It is registered from state, with no combinational path from frm_ready.
- Packing: accepted beat k is written to slot k; the counter increments; parity ^= d_data. Unwritten slots stay 0.
- FSM states are cStateT encodings: IDLE=4'h0, COLLECT=4'h1, EMIT=4'h2. All other codes go to IDLE.
- IDLE transitions:
  - beat accepted and FRAME_LEN==1 -> EMIT
  - beat accepted -> COLLECT
  - flush with no beat -> ignored, stay IDLE
  - flush together with an accepted beat -> EMIT, count 1
- COLLECT transitions:
  - beat accepted and count+1 == FRAME_LEN -> EMIT
  - flush (with or without a beat) -> EMIT; the beat accepted in that cycle is included
- EMIT:
  - frm_valid=1, and frm_data, frm_count and frm_parity are held stable until frm_ready.
  - On the frm_valid && frm_ready cycle: the slots, counter and parity clear, and the state goes to IDLE.
  - d_ready returns to 1 on the next cycle (no same-cycle bypass).
  - flush and d_valid are ignored in EMIT.
- Latency: if the last beat (or flush) is accepted in cycle N, frm_valid=1 in cycle N+1. Minimum frame-to-frame gap is one cycle of d_ready=1 after the handshake.
- Width rules:
  - The counter is never wider than CNT_W; FRAME_LEN<=15 is guaranteed by an elaboration check.
  - Parity is D_W-bit XOR with no carry.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values immediately; no frame is emitted.
- Upstream protocol: d_data is sampled only on acceptance. A d_valid drop between beats does not stall or time out the frame.

Decomposition:
- hierIncludeCInclude_package: reuse C_ANOTHER_SIZE, D_SIZE, dT, dSt and cStateT from the existing package. Add to the same package:
  - the state localparams ST_IDLE/ST_COLLECT/ST_EMIT (cStateT)
  - a frmSt struct {frm_parity dT; frm_count logic[3:0]; frm_data dT[C_ANOTHER_SIZE]}
- Sub-module d_frame_slot_reg: slot array plus write-index decode, with load/clear inputs. The FSM and counter stay in the top module.

Test Plan:
- Full frame: 10 beats 0,1,2,3,4,5,6,7,0,1 with frm_ready=1 -> one cycle after beat 10, frm_valid=1, frm_count=10, frm_parity=3'h1, slot i equals beat i.
- Backpressure: full frame with frm_ready=0 for 5 cycles -> frm_valid, frm_data and frm_count stable, d_ready=0 throughout. The handshake in cycle 6 returns state to IDLE, with d_ready=1 the next cycle.
- Partial flush: beats 5,5,2, then flush alone -> frm_count=3, frm_data=30'h000000AD, frm_parity=3'h2.
- Flush with beat: beats 1,2,3, then beat 4 in the same cycle as flush -> frm_count=4, beat 4 in slot 3, frm_parity=3'h4.
- Idle flush: flush pulses in IDLE with d_valid=0 -> frm_valid stays 0, state stays 4'h0.
- Reset mid-frame: 6 beats accepted, rst_n low 2 cycles, then a full 10-beat frame -> no stale data; the first frame seen has frm_count=10 and correct parity.
